// File: rtl/uart_tx_queue_if.sv
// Producer and transceiver-facing signal bundle for uart_tx_queue.
// The slave modport is the queue's view; master is the driver side.
interface uart_tx_queue_if #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 8
);
  logic                  wr_en;
  logic [DATA_W-1:0]     wr_data;
  logic                  flush;
  logic                  ovf_clr;
  logic                  full;
  logic                  empty;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;
  logic                  busy;
  logic [DATA_W-1:0]     tx_data;
  logic                  tx_wr;
  logic                  tx_done;

  modport master (
    output wr_en, wr_data, flush, ovf_clr, tx_done,
    input  full, empty, count, overflow, busy, tx_data, tx_wr
  );

  modport slave (
    input  wr_en, wr_data, flush, ovf_clr, tx_done,
    output full, empty, count, overflow, busy, tx_data, tx_wr
  );
endinterface

// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding a UART transmitter one byte at a time, waiting for
// tx_done after each tx_wr pulse so back-to-back bytes never collide.
module uart_tx_queue #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 8
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  uart_tx_queue_if.slave  bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE    = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT
  } state_t;

  state_t                 state;
  state_t                 next_state;
  logic [DATA_W-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0]  rd_ptr;
  logic [DEPTH_LOG2-1:0]  wr_ptr;
  logic [DEPTH_LOG2:0]    count;
  logic                   overflow;
  logic [DATA_W-1:0]      tx_data;
  logic                   tx_wr;
  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;
  logic                   drop;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // A push racing a flush is discarded silently; only a full FIFO drops with overflow.
  assign push = bus.wr_en && !full && !bus.flush;
  assign drop = bus.wr_en && full && !bus.flush;

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty && !bus.flush) begin
          pop        = 1'b1;
          next_state = S_SEND;
        end
      end
      S_SEND:  next_state = S_WAIT;
      S_WAIT:  if (bus.tx_done) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  // flush clears the queue but never touches the byte already handed to the transmitter.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      tx_data  <= '0;
      tx_wr    <= 1'b0;
    end else begin
      tx_wr <= pop;
      if (pop) begin
        tx_data <= mem[rd_ptr];
      end

      if (bus.flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        case ({push, pop})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end

      if (drop) begin
        overflow <= 1'b1;
      end else if (bus.ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = count;
  assign bus.overflow = overflow;
  assign bus.busy     = (state != S_IDLE);
  assign bus.tx_data  = tx_data;
  assign bus.tx_wr    = tx_wr;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue: reset, single and multi-byte sends,
// overflow, asynchronous reset mid-transfer and flush during a transfer.
module tb_uart_tx_queue;

  logic sys_clk;
  logic sys_rst_n;
  int   vectors;
  int   miscompares;

  uart_tx_queue_if #(.DEPTH_LOG2(4), .DATA_W(8)) bus ();

  uart_tx_queue #(.DEPTH_LOG2(4), .DATA_W(8)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Each step advances one rising edge and leaves time 1 ns past it for sampling.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic wr, input logic [7:0] data);
    bus.wr_en   = wr;
    bus.wr_data = data;
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic ack();
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
  endtask

  logic [7:0] seq [3];

  initial begin
    vectors      = 0;
    miscompares  = 0;
    bus.wr_en    = 1'b0;
    bus.wr_data  = 8'h00;
    bus.flush    = 1'b0;
    bus.ovf_clr  = 1'b0;
    bus.tx_done  = 1'b0;
    sys_rst_n    = 1'b0;
    seq[0] = 8'hA1;
    seq[1] = 8'hA2;
    seq[2] = 8'hA3;

    // 1: reset state
    repeat (3) step();
    sys_rst_n = 1'b1;
    step();
    check_output("rst_tx_wr",    32'(bus.tx_wr),    32'd0);
    check_output("rst_busy",     32'(bus.busy),     32'd0);
    check_output("rst_empty",    32'(bus.empty),    32'd1);
    check_output("rst_count",    32'(bus.count),    32'd0);
    check_output("rst_overflow", 32'(bus.overflow), 32'd0);
    check_output("rst_tx_data",  32'(bus.tx_data),  32'h00);

    // 2: single byte, tx_wr one cycle starting one edge after the push edge
    apply_stimulus(1'b1, 8'h55);
    check_output("t2_wr_early",  32'(bus.tx_wr),    32'd0);
    check_output("t2_count1",    32'(bus.count),    32'd1);
    step();
    check_output("t2_tx_wr",     32'(bus.tx_wr),    32'd1);
    check_output("t2_tx_data",   32'(bus.tx_data),  32'h55);
    check_output("t2_busy",      32'(bus.busy),     32'd1);
    check_output("t2_count0",    32'(bus.count),    32'd0);
    step();
    check_output("t2_wr_low",    32'(bus.tx_wr),    32'd0);
    repeat (3) step();
    check_output("t2_busy_wait", 32'(bus.busy),     32'd1);
    check_output("t2_data_hold", 32'(bus.tx_data),  32'h55);
    ack();
    check_output("t2_idle",      32'(bus.busy),     32'd0);
    step();
    check_output("t2_no_wr",     32'(bus.tx_wr),    32'd0);

    // 3: three bytes back-to-back, each released two edges after tx_done
    bus.wr_en   = 1'b1;
    bus.wr_data = seq[0];
    step();
    bus.wr_data = seq[1];
    step();
    check_output("t3_wr0",       32'(bus.tx_wr),    32'd1);
    check_output("t3_data0",     32'(bus.tx_data),  32'(seq[0]));
    bus.wr_data = seq[2];
    step();
    bus.wr_en   = 1'b0;
    check_output("t3_count2",    32'(bus.count),    32'd2);
    for (int i = 1; i < 3; i++) begin
      repeat (8) step();
      ack();
      check_output("t3_gap",     32'(bus.tx_wr),    32'd0);
      step();
      check_output("t3_wr",      32'(bus.tx_wr),    32'd1);
      check_output("t3_data",    32'(bus.tx_data),  32'(seq[i]));
      step();
    end
    repeat (8) step();
    ack();
    check_output("t3_empty",     32'(bus.empty),    32'd1);
    check_output("t3_idle",      32'(bus.busy),     32'd0);

    // 4: 18 pushes with no tx_done: one in flight, 16 queued, one dropped
    bus.wr_en = 1'b1;
    for (int i = 0; i < 18; i++) begin
      bus.wr_data = 8'(8'h10 + i);
      step();
    end
    bus.wr_en = 1'b0;
    check_output("t4_full",      32'(bus.full),     32'd1);
    check_output("t4_count",     32'(bus.count),    32'd16);
    check_output("t4_overflow",  32'(bus.overflow), 32'd1);
    check_output("t4_inflight",  32'(bus.tx_data),  32'h10);
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;
    check_output("t4_ovf_clr",   32'(bus.overflow), 32'd0);
    check_output("t4_still_full",32'(bus.full),     32'd1);

    // 5: async reset while waiting with 4 queued
    sys_rst_n = 1'b0;
    step();
    sys_rst_n = 1'b1;
    bus.wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.wr_data = 8'(8'h30 + i);
      step();
    end
    bus.wr_en = 1'b0;
    step();
    check_output("t5_count4",    32'(bus.count),    32'd4);
    check_output("t5_busy",      32'(bus.busy),     32'd1);
    sys_rst_n = 1'b0;
    #2;
    check_output("t5_rst_wr",    32'(bus.tx_wr),    32'd0);
    check_output("t5_rst_busy",  32'(bus.busy),     32'd0);
    check_output("t5_rst_count", 32'(bus.count),    32'd0);
    step();
    sys_rst_n = 1'b1;
    ack();
    step();
    check_output("t5_no_wr",     32'(bus.tx_wr),    32'd0);
    check_output("t5_no_busy",   32'(bus.busy),     32'd0);

    // 6: flush while waiting with 5 queued and a push on the same edge
    bus.wr_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.wr_data = 8'(8'h60 + i);
      step();
    end
    bus.wr_en = 1'b0;
    step();
    check_output("t6_count5",    32'(bus.count),    32'd5);
    bus.flush   = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hEE;
    step();
    bus.flush   = 1'b0;
    bus.wr_en   = 1'b0;
    check_output("t6_count0",    32'(bus.count),    32'd0);
    check_output("t6_empty",     32'(bus.empty),    32'd1);
    check_output("t6_overflow",  32'(bus.overflow), 32'd0);
    check_output("t6_busy",      32'(bus.busy),     32'd1);
    check_output("t6_inflight",  32'(bus.tx_data),  32'h60);
    ack();
    check_output("t6_done",      32'(bus.busy),     32'd0);
    step();
    step();
    check_output("t6_no_wr",     32'(bus.tx_wr),    32'd0);
    check_output("t6_idle",      32'(bus.busy),     32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
